// File: rtl/vz_pkg.sv
// Shared types and constants for the VZ image loader.
// Holds the parser state enum, header constants and the RAM write bundle.
package vz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DRAIN,
        ST_PTR_LO,
        ST_PTR_HI,
        ST_EXEC,
        ST_ERR
    } vz_state_t;

    localparam int         VZ_HDR_LEN    = 24;
    localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
    localparam logic [7:0] VZ_TYPE_MCODE = 8'hF1;

    localparam logic [7:0] VZ_MAGIC_0    = 8'h56; // 'V'
    localparam logic [7:0] VZ_MAGIC_1    = 8'h5A; // 'Z'
    localparam logic [7:0] VZ_MAGIC_2    = 8'h46; // 'F'
    localparam logic [7:0] VZ_MAGIC_3A   = 8'h30; // '0'
    localparam logic [7:0] VZ_MAGIC_3B   = 8'h4F; // 'O'

    // One pending RAM write: target address plus data byte.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } vz_wr_t;

    // Header byte validity: magic at 0..3, type at 21, all others free.
    function automatic logic vz_hdr_byte_ok(
        input logic [4:0] pos,
        input logic [7:0] b
    );
        logic ok;
        ok = 1'b1;
        case (pos)
            5'd0:    ok = (b == VZ_MAGIC_0);
            5'd1:    ok = (b == VZ_MAGIC_1);
            5'd2:    ok = (b == VZ_MAGIC_2);
            5'd3:    ok = (b == VZ_MAGIC_3A) || (b == VZ_MAGIC_3B);
            5'd21:   ok = (b == VZ_TYPE_BASIC) || (b == VZ_TYPE_MCODE);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vz_byte_fifo.sv
// Small payload FIFO holding {addr,data} RAM writes for the VZ loader.
// Ports: clk_sys, reset (sync, high), push/push_data, pop, head, count, full, empty.
module vz_byte_fifo
    import vz_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  vz_wr_t                   push_data,
    input  logic                     pop,
    output vz_wr_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    vz_wr_t          mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still taken when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wp] <= push_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vz_image_loader.sv
// VZ image loader: parses the hps_io .VZ byte stream and writes it into RAM.
// Ports: ioctl_* in (wait out), mem_req/addr/data/ack, busy, exec_req/addr, load_err.
module vz_image_loader
    import vz_pkg::*;
#(
    parameter logic [7:0]  VZ_INDEX      = 8'd1,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] BASIC_END_PTR = 16'h78F9
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        exec_req,
    output logic [15:0] exec_addr,
    output logic        load_err
);

    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);
    localparam logic [15:0]   HDR_LEN  = 16'(VZ_HDR_LEN);

    vz_state_t     state;
    vz_state_t     state_nx;

    logic          active;
    logic          active_q;
    logic          rise;
    logic          start_pend;
    logic          start_go;
    logic          wr_in;
    logic          hdr_ok;
    logic          fifo_phase;

    logic [15:0]   cnt;
    logic [15:0]   start_addr;
    logic [15:0]   end_ptr;
    logic          is_mcode;
    logic          err_q;

    logic          req_q;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;

    logic          f_push;
    logic          f_pop;
    vz_wr_t        f_in;
    vz_wr_t        f_head;
    logic [CW-1:0] f_count;
    logic          f_full;
    logic          f_empty;
    logic          overflow;

    assign active     = ioctl_download && (ioctl_index == VZ_INDEX);
    assign rise       = active && !active_q;
    assign wr_in      = ioctl_wr && active;
    assign hdr_ok     = vz_hdr_byte_ok(cnt[4:0], ioctl_dout);
    assign start_go   = (state == ST_IDLE) && active
                        && (rise || start_pend);
    assign fifo_phase = (state == ST_DATA) || (state == ST_DRAIN);
    assign end_ptr    = start_addr + cnt - HDR_LEN;

    assign f_push     = wr_in && (state == ST_DATA);
    assign f_pop      = mem_ack && req_q && fifo_phase;
    assign f_in       = '{addr: start_addr + cnt - HDR_LEN,
                          data: ioctl_dout};
    assign overflow   = f_push && f_full && !f_pop;

    vz_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (f_push),
        .push_data (f_in),
        .pop       (f_pop),
        .head      (f_head),
        .count     (f_count),
        .full      (f_full),
        .empty     (f_empty)
    );

    always_comb begin
        state_nx   = state;
        ioctl_wait = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_go) state_nx = ST_HDR;
            end
            ST_HDR: begin
                if (!active) begin
                    state_nx = ST_IDLE;
                end else if (wr_in) begin
                    if (!hdr_ok)
                        state_nx = ST_ERR;
                    else if (cnt == HDR_LEN - 16'd1)
                        state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!active) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (f_empty && !req_q)
                    state_nx = is_mcode ? ST_EXEC : ST_PTR_LO;
            end
            ST_PTR_LO: begin
                if (mem_ack && req_q) state_nx = ST_PTR_HI;
            end
            ST_PTR_HI: begin
                if (mem_ack && req_q) state_nx = ST_IDLE;
            end
            ST_EXEC: begin
                state_nx = ST_IDLE;
            end
            ST_ERR: begin
                if (!active) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // Wait trips one entry early so a strobe already in flight
        // from hps_io still finds a free slot.
        if (active) begin
            unique case (1'b1)
                (state == ST_IDLE):
                    ioctl_wait = start_pend;
                (state == ST_DATA):
                    ioctl_wait = (f_count >= WAIT_LVL);
                (state == ST_DRAIN) || (state == ST_PTR_LO) ||
                (state == ST_PTR_HI) || (state == ST_EXEC):
                    ioctl_wait = 1'b1;
                default:
                    ioctl_wait = 1'b0;
            endcase
        end
    end

    // active_q tracks the raw level even through reset, so a reset
    // issued mid-download is not mistaken for a fresh start.
    always_ff @(posedge clk_sys) begin
        active_q <= active;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
            cnt        <= '0;
            start_addr <= '0;
            is_mcode   <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state <= state_nx;

            if ((state == ST_IDLE) || !active)
                start_pend <= 1'b0;
            else if (rise)
                start_pend <= 1'b1;

            if (start_go)
                cnt <= '0;
            else if (wr_in && ((state == ST_HDR) || (state == ST_DATA)))
                cnt <= cnt + 16'd1;

            if ((state == ST_HDR) && wr_in) begin
                if (cnt == 16'd21)
                    is_mcode <= (ioctl_dout == VZ_TYPE_MCODE);
                if (cnt == 16'd22)
                    start_addr[7:0] <= ioctl_dout;
                if (cnt == 16'd23)
                    start_addr[15:8] <= ioctl_dout;
            end

            if (start_go)
                err_q <= 1'b0;
            else if (((state == ST_HDR) && (!active || (wr_in && !hdr_ok)))
                     || overflow)
                err_q <= 1'b1;

            // Request register: a write is held until acked, then
            // drops for one cycle before the next one is loaded.
            if (req_q) begin
                if (mem_ack) req_q <= 1'b0;
            end else if (fifo_phase && !f_empty) begin
                req_q  <= 1'b1;
                addr_q <= f_head.addr;
                data_q <= f_head.data;
            end else if (state == ST_PTR_LO) begin
                req_q  <= 1'b1;
                addr_q <= BASIC_END_PTR;
                data_q <= end_ptr[7:0];
            end else if (state == ST_PTR_HI) begin
                req_q  <= 1'b1;
                addr_q <= BASIC_END_PTR + 16'd1;
                data_q <= end_ptr[15:8];
            end

            // hps_io offset must track the internal byte position.
            if (wr_in && ((state == ST_HDR) || (state == ST_DATA)))
                assert (ioctl_addr == cnt);
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign busy      = (state != ST_IDLE);
    assign exec_req  = (state == ST_EXEC);
    assign exec_addr = exec_req ? start_addr : 16'h0000;
    assign load_err  = err_q;

endmodule

// File: tb/tb_vz_image_loader.sv
// Self-checking bench for vz_image_loader: image table plus corner sequences.
// A scoreboard queue holds expected RAM writes, compared on each arbiter ack.
module tb_vz_image_loader;

    localparam logic [7:0]  VZ_IDX = 8'd1;
    localparam logic [15:0] BEP    = 16'h78F9;
    localparam logic [31:0] M_VZF0 = 32'h565A4630;
    localparam logic [31:0] M_VZFO = 32'h565A464F;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        exec_req;
    logic [15:0] exec_addr;
    logic        load_err;

    always #5 clk_sys = ~clk_sys;

    vz_image_loader #(
        .VZ_INDEX      (VZ_IDX),
        .FIFO_DEPTH    (4),
        .BASIC_END_PTR (BEP)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .exec_req       (exec_req),
        .exec_addr      (exec_addr),
        .load_err       (load_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    bit          ack_hold = 1'b0;
    int          exec_cnt = 0;
    logic [15:0] exec_seen = 16'h0;
    logic [15:0] offs = 16'h0;

    // Arbiter model and scoreboard: ack one cycle, compare on accept.
    always @(negedge clk_sys) begin
        if (exec_req) begin
            exec_cnt++;
            exec_seen = exec_addr;
        end
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !ack_hold) begin
            mem_ack = 1'b1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got %0h=%0h want none",
                         mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_data), 32'(e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        if (ioctl_wait) begin
            ioctl_wr = 1'b0;
            while (ioctl_wait && g < 1000) begin
                @(negedge clk_sys);
                g++;
            end
            if (g >= 1000) begin
                n_chk++;
                $display("FAIL wait_timeout: got wait=1 want 0");
            end
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = offs;
        ioctl_dout = b;
        offs       = offs + 16'd1;
        @(negedge clk_sys);
    endtask

    task automatic send_header(input logic [31:0] magic,
                               input logic [7:0] typ,
                               input logic [15:0] start);
        logic [31:0] m;
        m = magic;
        ioctl_index    = VZ_IDX;
        ioctl_download = 1'b1;
        offs           = 16'h0;
        @(negedge clk_sys);
        send_byte(m[31:24]);
        send_byte(m[23:16]);
        send_byte(m[15:8]);
        send_byte(m[7:0]);
        for (int k = 0; k < 17; k++) send_byte(8'h41);
        send_byte(typ);
        send_byte(start[7:0]);
        send_byte(start[15:8]);
    endtask

    function automatic logic [7:0] pay(input int i);
        return 8'((i + 1) * 17);
    endfunction

    task automatic run_image(input logic [31:0] magic,
                             input logic [7:0] typ,
                             input logic [15:0] start, input int n);
        bit          ok;
        logic [15:0] fin;
        ok = ((magic == M_VZF0) || (magic == M_VZFO)) &&
             ((typ == 8'hF0) || (typ == 8'hF1));
        send_header(magic, typ, start);
        for (int i = 0; i < n; i++) begin
            if (ok) exp_q.push_back({start + 16'(i), pay(i)});
            send_byte(pay(i));
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        if (ok && typ == 8'hF0) begin
            fin = start + 16'(n);
            exp_q.push_back({BEP, fin[7:0]});
            exp_q.push_back({BEP + 16'd1, fin[15:8]});
        end
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (busy && g < 500) begin
            @(negedge clk_sys);
            g++;
        end
        chk(name, 32'(busy), 32'd0);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wait"},   32'(ioctl_wait), 32'd0);
        chk({tag, "_req"},    32'(mem_req),    32'd0);
        chk({tag, "_addr"},   32'(mem_addr),   32'd0);
        chk({tag, "_data"},   32'(mem_data),   32'd0);
        chk({tag, "_busy"},   32'(busy),       32'd0);
        chk({tag, "_exec"},   32'(exec_req),   32'd0);
        chk({tag, "_eaddr"},  32'(exec_addr),  32'd0);
        chk({tag, "_err"},    32'(load_err),   32'd0);
    endtask

    typedef struct {
        logic [31:0] magic;
        logic [7:0]  typ;
        logic [15:0] start;
        int          n;
        bit          exp_err;
        int          exp_exec;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_wait;
        int seen;

        vecs[0] = '{M_VZF0, 8'hF0, 16'h7AE9, 3, 1'b0, 0};
        vecs[1] = '{M_VZFO, 8'hF1, 16'h8000, 2, 1'b0, 1};
        vecs[2] = '{32'h41424344, 8'hF0, 16'h7AE9, 3, 1'b1, 0};
        vecs[3] = '{M_VZF0, 8'hF0, 16'hFFFE, 4, 1'b0, 0};
        vecs[4] = '{M_VZF0, 8'hF0, 16'h7000, 0, 1'b0, 0};
        vecs[5] = '{M_VZF0, 8'h22, 16'h8000, 2, 1'b1, 0};

        repeat (3) @(negedge clk_sys);
        chk_all_zero("rst");
        reset = 1'b0;
        @(negedge clk_sys);

        for (int v = 0; v < 6; v++) begin
            exec_cnt = 0;
            run_image(vecs[v].magic, vecs[v].typ, vecs[v].start, vecs[v].n);
            wait_idle("img_busy");
            chk("img_pending", 32'(exp_q.size()), 32'd0);
            chk("img_err", 32'(load_err), 32'(vecs[v].exp_err));
            chk("img_exec_cnt", 32'(exec_cnt), 32'(vecs[v].exp_exec));
            if (vecs[v].exp_exec != 0)
                chk("img_exec_addr", 32'(exec_seen), 32'(vecs[v].start));
        end

        // Payload byte to mem_req latency with an idle arbiter.
        exec_cnt = 0;
        send_header(M_VZF0, 8'hF1, 16'h4000);
        exp_q.push_back({16'h4000, 8'h5A});
        send_byte(8'h5A);
        ioctl_wr = 1'b0;
        chk("lat_cycle1", 32'(mem_req), 32'd0);
        @(negedge clk_sys);
        chk("lat_cycle2", 32'(mem_req), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'h4000);
        ioctl_download = 1'b0;
        wait_idle("lat_busy");
        chk("lat_exec", 32'(exec_cnt), 32'd1);
        chk("lat_eaddr", 32'(exec_seen), 32'h4000);

        // Arbiter stalls 20 cycles while bytes arrive back to back.
        exec_cnt   = 0;
        first_wait = -1;
        send_header(M_VZF0, 8'hF1, 16'hC000);
        ack_hold = 1'b1;
        fork
            begin
                repeat (20) @(negedge clk_sys);
                ack_hold = 1'b0;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            if (ioctl_wait && first_wait < 0) first_wait = i;
            exp_q.push_back({16'hC000 + 16'(i), pay(i)});
            send_byte(pay(i));
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        wait_idle("bp_busy");
        chk("bp_wait_at", 32'(first_wait), 32'd3);
        chk("bp_pending", 32'(exp_q.size()), 32'd0);
        chk("bp_err", 32'(load_err), 32'd0);
        chk("bp_exec", 32'(exec_cnt), 32'd1);

        // Reset in the middle of the payload.
        exec_cnt = 0;
        send_header(M_VZF0, 8'hF0, 16'h7AE9);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({16'h7AE9 + 16'(i), pay(i)});
            send_byte(pay(i));
        end
        ioctl_wr = 1'b0;
        reset    = 1'b1;
        @(posedge clk_sys);
        #1;
        chk_all_zero("midrst");
        @(negedge clk_sys);
        reset          = 1'b0;
        ioctl_download = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (30) begin
            @(negedge clk_sys);
            if (mem_req || busy) seen++;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);
        chk("midrst_exec", 32'(exec_cnt), 32'd0);

        // Foreign download slot must be ignored.
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        offs           = 16'h0;
        seen           = 0;
        @(negedge clk_sys);
        for (int i = 0; i < 30; i++) begin
            send_byte(8'h56 + 8'(i));
            if (ioctl_wait || busy || mem_req) seen++;
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("idx0_quiet", 32'(seen), 32'd0);
        chk("idx0_err", 32'(load_err), 32'd0);
        chk("idx0_exec", 32'(exec_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
